multicycle_ctrl: RTL

- Multi-cycle control FSM that is the initiator side of the ALU interface: it decodes the instruction register and drives alu_ctrl and the operand-select lines, and consumes the ALU zero flag for BEQ.
- Sits in the multi-cycle CPU datapath between the instruction register, memory port, register file and ALU.
- Replaces the single-cycle combinational decoder with a sequenced FETCH/DECODE/EXECUTE/MEM/WB flow and a memory-ready handshake.

---
 rtl/multicycle_ctrl_if.sv | 31 +++
 rtl/multicycle_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multi-cycle FSM and the datapath (IR, memory port, regfile, ALU).
interface multicycle_ctrl_if #(parameter int ALU_CTRL_W = 4);
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  zero;
    logic                  mem_ready;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic                  pc_en;
    logic [1:0]            pc_src;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  reg_write;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  illegal;
    logic [3:0]            state;
    modport master (
        input  opcode, funct, zero, mem_ready,
        output alu_ctrl, alu_src_a, alu_src_b, pc_en, pc_src, i_or_d, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, illegal, state
    );
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  alu_ctrl, alu_src_a, alu_src_b, pc_en, pc_src, i_or_d, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving the ALU and datapath strobes.
module multicycle_ctrl #(
    parameter int ALU_CTRL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] EXEC_R   = 4'd2;
    localparam logic [3:0] EXEC_I   = 4'd3;
    localparam logic [3:0] MEM_ADDR = 4'd4;
    localparam logic [3:0] MEM_RD   = 4'd5;
    localparam logic [3:0] MEM_WB   = 4'd6;
    localparam logic [3:0] MEM_WR   = 4'd7;
    localparam logic [3:0] R_WB     = 4'd8;
    localparam logic [3:0] I_WB     = 4'd9;
    localparam logic [3:0] BRANCH   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(4'b0000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(4'b0001);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(4'b0011);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'b0110);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(4'b0111);
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = ALU_CTRL_W'(4'b1100);

    logic [3:0]            state_q;
    logic [3:0]            state_d;
    logic [ALU_CTRL_W-1:0] funct_alu;
    logic                  funct_ok;
    logic is_r, is_lw, is_sw, is_addi, is_beq, is_j, op_ok;
    logic in_fetch, in_decode, in_exec_r, in_exec_i, in_mem_addr, in_mem_rd;
    logic in_mem_wb, in_mem_wr, in_r_wb, in_i_wb, in_branch, in_jump;

    assign is_r    = bus.opcode == 6'b000000;
    assign is_lw   = bus.opcode == 6'b100011;
    assign is_sw   = bus.opcode == 6'b101011;
    assign is_addi = bus.opcode == 6'b001000;
    assign is_beq  = bus.opcode == 6'b000100;
    assign is_j    = bus.opcode == 6'b000010;
    assign op_ok   = is_r | is_lw | is_sw | is_addi | is_beq | is_j;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (bus.funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b100111: funct_alu = ALU_NOR;
            6'b101010: funct_alu = ALU_SLT;
            6'b000000: funct_alu = ALU_SLL;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE:   state_d = is_r ? EXEC_R : (is_lw | is_sw) ? MEM_ADDR : is_addi ? EXEC_I :
                                is_beq ? BRANCH : is_j ? JUMP : FETCH;
            EXEC_R:   state_d = funct_ok ? R_WB : FETCH;
            EXEC_I:   state_d = I_WB;
            MEM_ADDR: state_d = is_sw ? MEM_WR : MEM_RD;
            MEM_RD:   state_d = bus.mem_ready ? MEM_WB : MEM_RD;
            MEM_WR:   state_d = bus.mem_ready ? FETCH : MEM_WR;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    assign in_fetch    = state_q == FETCH;
    assign in_decode   = state_q == DECODE;
    assign in_exec_r   = state_q == EXEC_R;
    assign in_exec_i   = state_q == EXEC_I;
    assign in_mem_addr = state_q == MEM_ADDR;
    assign in_mem_rd   = state_q == MEM_RD;
    assign in_mem_wb   = state_q == MEM_WB;
    assign in_mem_wr   = state_q == MEM_WR;
    assign in_r_wb     = state_q == R_WB;
    assign in_i_wb     = state_q == I_WB;
    assign in_branch   = state_q == BRANCH;
    assign in_jump     = state_q == JUMP;

    // Every output is qualified by rst_n so nothing fires while reset is held, even though FETCH is a requesting state.
    assign bus.state      = state_q;
    assign bus.mem_read   = rst_n & (in_fetch | in_mem_rd);
    assign bus.mem_write  = rst_n & in_mem_wr;
    assign bus.i_or_d     = rst_n & (in_mem_rd | in_mem_wr);
    assign bus.ir_write   = rst_n & in_fetch & bus.mem_ready;
    assign bus.pc_en      = rst_n & ((in_fetch & bus.mem_ready) | (in_branch & bus.zero) | in_jump);
    assign bus.pc_src     = !rst_n ? 2'b00 : in_branch ? 2'b01 : in_jump ? 2'b10 : 2'b00;
    assign bus.alu_src_a  = rst_n & (in_exec_r | in_exec_i | in_mem_addr | in_branch);
    assign bus.alu_src_b  = !rst_n ? 2'b00 : in_fetch ? 2'b01 : in_decode ? 2'b11 :
                            (in_exec_i | in_mem_addr) ? 2'b10 : 2'b00;
    assign bus.alu_ctrl   = !rst_n ? ALU_ADD : in_exec_r ? funct_alu : in_branch ? ALU_SUB : ALU_ADD;
    assign bus.reg_write  = rst_n & (in_r_wb | in_i_wb | in_mem_wb);
    assign bus.reg_dst    = rst_n & in_r_wb;
    assign bus.mem_to_reg = rst_n & in_mem_wb;
    assign bus.illegal    = rst_n & ((in_decode & !op_ok) | (in_exec_r & !funct_ok));
endmodule
